ram_write_packer: RTL and testbench
===================================

Name: ram_write_packer

Overview:
- Upstream feeder of ram_mux: gathers the 8-bit client pixel/byte stream into 768-bit RAM words.
- Drives the ram_mux write side: write_data, write_ram, write_address.
- Tracks word position within a frame and pulses new_frame once a frame has been fully handed to ram_mux.
- Two-entry buffering (assembly register plus holding register) absorbs ram_mux back-pressure without stalling the byte stream.

Parameters:
- DATA_W, 768, RAM word width; must be a multiple of 8.
- ADDR_W, 32, write_address width.
- ADDR_STEP, 6, address increment per word (six 128-bit DDR beats).
- FRAME_BASE, 0, address of word 0 of every frame.
- FRAME_WORDS, 1600, words per frame; must be at least 1.

Ports:
- clk0_tb, in, 1, system clock.
- rst0_tb, in, 1, asynchronous active-low reset.
- in_data, in, 8, stream byte.
- in_valid, in, 1, in_data is valid.
- in_sof, in, 1, qualifies the first byte of a frame; ignored unless in_valid is high.
- in_ready, out, 1, packer accepts a byte this cycle.
- wr_ready, in, 1, ram_mux can take a write this cycle.
- write_data, out, DATA_W, word handed to ram_mux.
- write_ram, out, 1, one-cycle write strobe.
- write_address, out, ADDR_W, address for write_data.
- new_frame, out, 1, one-cycle pulse: frame completely written.
- sync_err, out, 1, sticky flag: frame resynchronised mid-word or mid-frame.

Behaviour:
- Reset (async, rst0_tb=0):
  - All outputs 0, except in_ready, which is 0 during reset and 1 on the first cycle after release.
  - Byte count, word index, state and both buffer-valid flags are cleared.
- Byte acceptance: a byte is accepted when in_valid && in_ready on a rising edge.
- State machine, states WAIT_SOF and FILL:
  - WAIT_SOF: in_ready=1. Bytes without in_sof are accepted and discarded. A byte with in_sof becomes byte 0 and the state moves to FILL.
  - FILL: bytes are packed MSB-first. Byte k lands in bits [DATA_W-1-8k -: 8]; byte count runs 0..DATA_W/8-1.
- Word completion:
  - On acceptance of the last byte (count 95), the full assembly word moves to the holding register on the next edge if holding is empty.
  - If holding is full, assembly stays full and in_ready drops to 0 until holding drains.
  - in_ready = !(assembly full && holding full).
- Write issue:
  - When holding is valid and wr_ready=1, write_ram=1 for exactly one cycle, with write_data and write_address stable in that cycle. Holding is freed on the same edge.
  - A holding register freed and refilled on the same edge is legal; back-to-back write_ram on consecutive cycles is allowed.
  - Latency: last byte accepted in cycle N, write_ram in cycle N+1 when holding was empty and wr_ready=1.
- Addressing:
  - write_address = FRAME_BASE + word_idx*ADDR_STEP, computed modulo 2^ADDR_W.
  - word_idx increments per word moved into holding.
- End of frame:
  - When word FRAME_WORDS-1 moves to holding, word_idx wraps to 0 and the state returns to WAIT_SOF.
  - new_frame pulses in the cycle after that word's write_ram.
- in_sof while in FILL (resync):
  - The partial assembly word is discarded and sync_err is set.
  - word_idx is reset to 0 and the sof byte becomes byte 0.
  - A pending holding word is still written, at its already latched address.
  - in_sof together with the last byte of a frame counts as a resync: that byte is not the frame end.
- sync_err clears only on reset.
- wr_ready held low indefinitely: the stream stalls with no data loss; 96 bytes plus one word are the maximum buffered.
- Reset mid-write: outputs drop asynchronously and the pending word is lost.

Decomposition:
- Shared package ram_if_pkg: DATA_W, ADDR_W, ADDR_STEP, and the FSM state encodings WAIT_SOF=1'b0, FILL=1'b1.
- One sub-module, byte_word_assembler: byte shift/count and the assembly-full flag.
- Top level holds the holding register, address generation, frame counter and FSM.

Test Plan:
- Reset, then in_sof with bytes 0x00..0x5F, wr_ready=1 → one write_ram one cycle after byte 0x5F, write_data[767:760]=8'h00, write_data[7:0]=8'h5F, write_address=0.
- Three consecutive words, FRAME_WORDS=3, wr_ready=1 → write_address values 0, 6, 12; new_frame pulses exactly once, one cycle after the third write_ram; state returns to WAIT_SOF.
- wr_ready=0 while 192 bytes are offered → in_ready falls after byte 192 is accepted; raising wr_ready → two write_ram pulses (addresses 0 then 6) with no byte lost or reordered.
- 40 bytes of a word, then in_sof with fresh data → sync_err=1; next write_ram carries the new bytes at address 0; the 40 stale bytes never appear.
- Bytes without in_sof after reset → no write_ram, in_ready stays 1, sync_err stays 0.
- rst0_tb pulsed low mid-word while holding is full → write_ram, new_frame and sync_err all 0 immediately; after release, a fresh frame writes at address 0.

Source files
------------

// File: rtl/ram_if_pkg.sv
// Shared constants and FSM encoding for the ram_mux write-side feeder.
// Defaults here are picked up as parameter defaults by the packer modules.
package ram_if_pkg;
  localparam int DATA_W    = 768;
  localparam int ADDR_W    = 32;
  localparam int ADDR_STEP = 6;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    FILL     = 1'b1
  } state_e;

  // Counter width that stays legal when the counted range collapses to one value.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ram_write_packer_assembler.sv
// Byte-to-word assembly: MSB-first byte placement, byte counter and assembly-full flag.
// A completed word either leaves immediately (via word_next) or parks here when defer is high.
module byte_word_assembler
  import ram_if_pkg::*;
#(
  parameter int DATA_W = ram_if_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              push,
  input  logic              defer,
  input  logic              take,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] word_next,
  output logic              last,
  output logic              full
);
  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = clog2_min1(NB);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d, idx;
  logic              full_q, full_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              wr;

  always_comb begin
    wr     = start || push;
    idx    = start ? '0 : cnt_q;
    last   = wr && (idx == LAST_IDX);
    cnt_d  = cnt_q;
    full_d = full_q;
    word_d = word_q;
    if (take) full_d = 1'b0;
    if (wr) begin
      cnt_d = last ? '0 : idx + 1'b1;
      if (last && defer) full_d = 1'b1;
      for (int k = 0; k < NB; k++) begin
        if (idx == CNT_W'(k)) word_d[DATA_W-1-8*k -: 8] = byte_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Assembly data needs no reset: every word is fully rewritten before it is used.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign word      = word_q;
  assign word_next = word_d;
  assign full      = full_q;
endmodule

// File: rtl/ram_write_packer.sv
// Packs the 8-bit client stream into RAM words for ram_mux: holding register,
// frame word counter, address generation, frame-sync FSM and status flags.
module ram_write_packer
  import ram_if_pkg::*;
#(
  parameter int DATA_W      = ram_if_pkg::DATA_W,
  parameter int ADDR_W      = ram_if_pkg::ADDR_W,
  parameter int ADDR_STEP   = ram_if_pkg::ADDR_STEP,
  parameter int FRAME_BASE  = 0,
  parameter int FRAME_WORDS = 1600
) (
  input  logic              clk0_tb,
  input  logic              rst0_tb,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  input  logic              wr_ready,
  output logic [DATA_W-1:0] write_data,
  output logic              write_ram,
  output logic [ADDR_W-1:0] write_address,
  output logic              new_frame,
  output logic              sync_err
);
  localparam int IDX_W = clog2_min1(FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(FRAME_WORDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic              hold_vld_q, hold_vld_d;
  logic              hold_last_q, hold_last_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic              new_frame_q, new_frame_d;
  logic              sync_err_q, sync_err_d;

  logic              acc, sof_acc, fill_acc, hold_free, move_full, move_direct;
  logic [DATA_W-1:0] asm_word, asm_word_next;
  logic              asm_last, asm_full;
  logic [ADDR_W-1:0] cur_addr;

  // Holding may be freed and refilled on the same edge, so a write frees it.
  assign in_ready    = rst0_tb && !(asm_full && hold_vld_q);
  assign acc         = in_valid && in_ready;
  assign sof_acc     = acc && in_sof;
  assign fill_acc    = acc && !in_sof && (state_q == FILL);
  assign write_ram   = hold_vld_q && wr_ready;
  assign hold_free   = !hold_vld_q || wr_ready;
  assign move_full   = asm_full && hold_free;
  assign move_direct = asm_last && hold_free;
  assign cur_addr    = ADDR_W'(FRAME_BASE) + ADDR_W'(word_idx_q) * ADDR_W'(ADDR_STEP);

  byte_word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk       (clk0_tb),
    .rst_n     (rst0_tb),
    .start     (sof_acc),
    .push      (fill_acc),
    .defer     (!hold_free),
    .take      (move_full),
    .byte_in   (in_data),
    .word      (asm_word),
    .word_next (asm_word_next),
    .last      (asm_last),
    .full      (asm_full)
  );

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    hold_vld_d  = hold_vld_q;
    hold_last_d = hold_last_q;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    sync_err_d  = sync_err_q;
    new_frame_d = write_ram && hold_last_q;

    if (sof_acc) begin
      state_d = FILL;
    end else if (fill_acc && asm_last && (word_idx_q == LAST_WORD)) begin
      state_d = WAIT_SOF;
    end
    if (sof_acc && (state_q == FILL)) sync_err_d = 1'b1;

    if (write_ram) hold_vld_d = 1'b0;
    if (move_full || move_direct) begin
      hold_vld_d  = 1'b1;
      hold_data_d = move_full ? asm_word : asm_word_next;
      hold_addr_d = cur_addr;
      hold_last_d = (word_idx_q == LAST_WORD);
      word_idx_d  = (word_idx_q == LAST_WORD) ? '0 : word_idx_q + 1'b1;
    end
    // A resync restarts the frame count after any pending word took its address.
    if (sof_acc) word_idx_d = '0;
  end

  always_ff @(posedge clk0_tb or negedge rst0_tb) begin
    if (!rst0_tb) begin
      state_q     <= WAIT_SOF;
      word_idx_q  <= '0;
      hold_vld_q  <= 1'b0;
      hold_last_q <= 1'b0;
      hold_data_q <= '0;
      hold_addr_q <= '0;
      new_frame_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      hold_vld_q  <= hold_vld_d;
      hold_last_q <= hold_last_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
      new_frame_q <= new_frame_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign write_data    = hold_data_q;
  assign write_address = hold_addr_q;
  assign new_frame     = new_frame_q;
  assign sync_err      = sync_err_q;
endmodule

// File: tb/tb_ram_write_packer.sv
// Scoreboard bench for ram_write_packer: a byte-list frame model queues expected
// writes, and a negedge monitor pops and compares them as write_ram appears.
module tb_ram_write_packer;
  localparam int DW   = 768;
  localparam int AW   = 32;
  localparam int STEP = 6;
  localparam int BASE = 0;
  localparam int FW   = 3;
  localparam int NB   = DW / 8;

  logic          clk0_tb = 1'b0;
  logic          rst0_tb = 1'b1;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_ready;
  logic          wr_ready = 1'b0;
  logic [DW-1:0] write_data;
  logic          write_ram;
  logic [AW-1:0] write_address;
  logic          new_frame;
  logic          sync_err;

  ram_write_packer #(
    .DATA_W(DW), .ADDR_W(AW), .ADDR_STEP(STEP), .FRAME_BASE(BASE), .FRAME_WORDS(FW)
  ) dut (
    .clk0_tb(clk0_tb), .rst0_tb(rst0_tb), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready), .wr_ready(wr_ready), .write_data(write_data),
    .write_ram(write_ram), .write_address(write_address), .new_frame(new_frame),
    .sync_err(sync_err)
  );

  always #5 clk0_tb = ~clk0_tb;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    bit            last;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] partial[$];
  int         wc;
  bit         in_frame;
  bit         exp_sync;
  bit         nf_pend;
  bit         rnd_wr;
  int         n_chk, n_fail;
  int         wr_count, nf_count;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Frame model: bytes gather in a list; every NB bytes of a frame form one word.
  task automatic model_byte(input logic [7:0] b, input bit sof);
    logic [DW-1:0] w;
    if (sof) begin
      if (in_frame) exp_sync = 1'b1;
      partial.delete();
      wc = 0;
      in_frame = 1'b1;
      partial.push_back(b);
    end else if (in_frame) begin
      partial.push_back(b);
    end
    if (in_frame && partial.size() == NB) begin
      w = '0;
      for (int k = 0; k < NB; k++) w[DW-1-8*k -: 8] = partial[k];
      exp_q.push_back('{data: w, addr: AW'(BASE + wc * STEP), last: (wc == FW - 1)});
      partial.delete();
      wc++;
      if (wc == FW) begin
        wc = 0;
        in_frame = 1'b0;
      end
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    partial.delete();
    wc = 0;
    in_frame = 1'b0;
    exp_sync = 1'b0;
    nf_pend = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof = 1'b0;
    repeat (n) begin
      @(posedge clk0_tb);
      #1;
      if (rnd_wr) wr_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit sof);
    bit acc;
    int waited;
    in_data = b;
    in_valid = 1'b1;
    in_sof = sof;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 500) begin
      @(negedge clk0_tb);
      acc = in_ready;
      @(posedge clk0_tb);
      #1;
      waited++;
      if (rnd_wr) wr_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    if (acc) model_byte(b, sof);
    else begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_accept_timeout: byte %0h not accepted in 500 cycles", b);
    end
  endtask

  task automatic do_reset();
    rst0_tb = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    wr_ready = 1'b0;
    rnd_wr = 1'b0;
    repeat (2) @(posedge clk0_tb);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_write_ram", write_ram, 0);
    chk("reset_new_frame", new_frame, 0);
    chk("reset_sync_err", sync_err, 0);
    chk("reset_write_address", write_address, 0);
    chk("reset_write_data", write_data, 0);
    model_clear();
    @(negedge clk0_tb);
    rst0_tb = 1'b1;
    #1;
    chk("in_ready_after_release", in_ready, 1);
    @(posedge clk0_tb);
    #1;
  endtask

  always @(negedge clk0_tb) begin
    if (rst0_tb) begin
      if (new_frame || nf_pend) chk("new_frame", new_frame, nf_pend);
      if (new_frame) nf_count++;
      nf_pend = 1'b0;
      if (write_ram) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: write at address %0h, expected no write", write_address);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_data", write_data, mon_e.data);
          chk("write_address", write_address, mon_e.addr);
          nf_pend = mon_e.last;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_wr, base_nf;
    n_chk = 0; n_fail = 0; wr_count = 0; nf_count = 0; rnd_wr = 1'b0;
    model_clear();
    #1;
    do_reset();

    // Bytes without a frame start are discarded.
    wr_ready = 1'b1;
    base_wr = wr_count;
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0);
    idle(3);
    chk("no_sof_in_ready", in_ready, 1);
    chk("no_sof_sync_err", sync_err, 0);
    chk("no_sof_writes", wr_count - base_wr, 0);

    // One word with ramp bytes, then the rest of a three-word frame.
    base_wr = wr_count;
    base_nf = nf_count;
    for (int i = 0; i < NB; i++) send_byte(8'(i), i == 0);
    @(negedge clk0_tb);
    chk("write_latency", write_ram, 1);
    chk("first_byte_msb", write_data[DW-1 -: 8], 8'h00);
    chk("last_byte_lsb", write_data[7:0], 8'h5f);
    chk("first_address", write_address, 0);
    @(posedge clk0_tb);
    #1;
    for (int i = 0; i < 2 * NB; i++) send_byte(8'($urandom), 1'b0);
    idle(5);
    chk("frame_writes", wr_count - base_wr, 3);
    chk("frame_new_frame_count", nf_count - base_nf, 1);
    base_wr = wr_count;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0);
    idle(3);
    chk("after_frame_discard", wr_count - base_wr, 0);
    chk("after_frame_sync_err", sync_err, 0);

    // Back-pressure: two words buffered, then drained in order.
    do_reset();
    base_wr = wr_count;
    for (int i = 0; i < 2 * NB - 1; i++) send_byte(8'($urandom), i == 0);
    @(negedge clk0_tb);
    chk("in_ready_before_full", in_ready, 1);
    @(posedge clk0_tb);
    #1;
    send_byte(8'($urandom), 1'b0);
    @(negedge clk0_tb);
    chk("in_ready_when_full", in_ready, 0);
    @(posedge clk0_tb);
    #1;
    wr_ready = 1'b1;
    idle(5);
    chk("backpressure_writes", wr_count - base_wr, 2);
    chk("backpressure_drained", exp_q.size(), 0);

    // Resync mid-word: stale bytes dropped, fresh word at address 0.
    do_reset();
    wr_ready = 1'b1;
    base_wr = wr_count;
    for (int i = 0; i < 40; i++) send_byte(8'hAA, i == 0);
    for (int i = 0; i < NB; i++) send_byte(8'($urandom), i == 0);
    idle(3);
    chk("resync_sync_err", sync_err, 1);
    chk("resync_writes", wr_count - base_wr, 1);
    chk("resync_drained", exp_q.size(), 0);

    // Reset while a word is pending in holding.
    do_reset();
    wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), i == 0);
    wr_ready = 1'b0;
    for (int i = 0; i < NB + 40; i++) send_byte(8'($urandom), i == 0);
    wr_ready = 1'b1;
    #1;
    chk("pending_write_before_reset", write_ram, 1);
    chk("sync_err_before_reset", sync_err, 1);
    rst0_tb = 1'b0;
    #1;
    chk("async_reset_write_ram", write_ram, 0);
    chk("async_reset_new_frame", new_frame, 0);
    chk("async_reset_sync_err", sync_err, 0);
    do_reset();
    wr_ready = 1'b1;
    base_wr = wr_count;
    base_nf = nf_count;
    for (int i = 0; i < FW * NB; i++) send_byte(8'($urandom), i == 0);
    idle(5);
    chk("post_reset_frame_writes", wr_count - base_wr, FW);
    chk("post_reset_new_frame", nf_count - base_nf, 1);
    chk("post_reset_sync_err", sync_err, 0);

    // Randomized stream with sparse frame starts, gaps and random back-pressure.
    do_reset();
    rnd_wr = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      send_byte(8'($urandom), (i == 0) || ($urandom_range(0, 299) == 0));
    end
    rnd_wr = 1'b0;
    wr_ready = 1'b1;
    idle(10);
    chk("random_drained", exp_q.size(), 0);
    chk("random_sync_err", sync_err, exp_sync);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
